// File: rtl/hgcal_input_packer_pkg.sv
// Shared types and helpers for the HGCAL input packer.
// Defaults, beat-count sizing, FSM states and the feature quantizer.
package hgcal_input_packer_pkg;

  localparam int IN_WIDTH_DEF   = 16;
  localparam int N_FEAT_DEF     = 48;
  localparam int FEAT_BEAT_DEF  = 4;
  localparam int BW_DEF         = 2;
  localparam int SHIFT_DEF      = 4;

  localparam int NB     = N_FEAT_DEF / FEAT_BEAT_DEF;
  localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    RESYNC
  } state_t;

  // Negative -> 0, else arithmetic shift then clamp to 2^bw-1.
  function automatic logic [31:0] quant_code(
    input logic signed [31:0] x,
    input int                 shift,
    input int                 bw
  );
    logic signed [31:0] q;
    logic [31:0]        maxc;
    maxc = (32'd1 << bw) - 32'd1;
    q    = x >>> shift;
    if (x < 0)
      return 32'd0;
    if ($unsigned(q) > maxc)
      return maxc;
    return $unsigned(q);
  endfunction

endpackage

// File: rtl/hgcal_feature_quantizer.sv
// One-lane combinational quantizer: signed raw word -> BW-bit code.
// Ports: x (raw signed feature), code (saturated unsigned code).
module hgcal_feature_quantizer
  import hgcal_input_packer_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int BW       = BW_DEF,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic signed [IN_WIDTH-1:0] x,
  output logic        [BW-1:0]       code
);

  logic signed [31:0] xe;

  assign xe   = 32'(x);
  assign code = BW'(quant_code(xe, SHIFT, BW));

endmodule

// File: rtl/hgcal_input_packer.sv
// Quantizes raw beats and packs a full frame into one wide output word.
// Ports: s_* input beat stream, m_* packed frame stream, frame_err pulse.
module hgcal_input_packer
  import hgcal_input_packer_pkg::*;
#(
  parameter int IN_WIDTH          = IN_WIDTH_DEF,
  parameter int N_FEATURES        = N_FEAT_DEF,
  parameter int FEATURES_PER_BEAT = FEAT_BEAT_DEF,
  parameter int BW                = BW_DEF,
  parameter int SHIFT             = SHIFT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [FEATURES_PER_BEAT*IN_WIDTH-1:0] s_data,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [N_FEATURES*BW-1:0]              m_data,
  output logic                                  frame_err
);

  localparam int NBEATS = N_FEATURES / FEATURES_PER_BEAT;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BEAT_W = FEATURES_PER_BEAT * BW;
  localparam int SH_W   = (NBEATS - 1) * BEAT_W;

  state_t              state, state_n;
  logic [CW-1:0]       beat_cnt;
  logic [SH_W-1:0]     shadow;
  logic [BEAT_W-1:0]   codes;
  logic                acc;
  logic                last_beat;
  logic                load;
  logic                err_n;

  for (genvar j = 0; j < FEATURES_PER_BEAT; j++) begin : g_lane
    hgcal_feature_quantizer #(
      .IN_WIDTH (IN_WIDTH),
      .BW       (BW),
      .SHIFT    (SHIFT)
    ) u_q (
      .x    ($signed(s_data[j*IN_WIDTH +: IN_WIDTH])),
      .code (codes[j*BW +: BW])
    );
  end

  // RESYNC keeps accepting so the stream can drain to the next last.
  assign s_ready   = (state != HOLD);
  assign acc       = s_valid && s_ready;
  assign last_beat = (beat_cnt == CW'(NBEATS - 1));

  always_comb begin
    state_n = state;
    load    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      FILL: begin
        if (acc) begin
          if (last_beat) begin
            if (s_last) begin
              load    = 1'b1;
              state_n = HOLD;
            end else begin
              err_n   = 1'b1;
              state_n = RESYNC;
            end
          end else if (s_last) begin
            err_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_ready)
          state_n = FILL;
      end
      RESYNC: begin
        if (acc && s_last)
          state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      beat_cnt  <= '0;
      shadow    <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      frame_err <= err_n;
      if (state == FILL && acc) begin
        if (last_beat || s_last)
          beat_cnt <= '0;
        else
          beat_cnt <= beat_cnt + CW'(1);
        if (!last_beat)
          shadow[int'(beat_cnt)*BEAT_W +: BEAT_W] <= codes;
      end
      // Final beat goes straight to the output, bypassing the shadow.
      if (load) begin
        m_data  <= {codes, shadow};
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed bench for hgcal_input_packer with a frame scoreboard.
// Drives beats on negedge, samples outputs off the active edge.
module tb_hgcal_input_packer;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [95:0] m_data;
  logic        frame_err;

  int checks;
  int passed;
  int errs;
  int outs;
  logic [95:0] last_out;
  logic [95:0] sb[$];

  hgcal_input_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] q_ref(input int x);
    if (x < 16) return 2'd0;
    if (x < 32) return 2'd1;
    if (x < 48) return 2'd2;
    return 2'd3;
  endfunction

  function automatic int raw(input int mode, input int seed,
                             input int b, input int j);
    if (mode == 0) return seed;
    if (mode == 2) begin
      if (b != 0) return 0;
      case (j)
        0: return -5;
        1: return 20;
        2: return 53;
        default: return 1000;
      endcase
    end
    return ((seed * 37 + b * 13 + j * 29) % 80) - 16;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) errs++;
    if (rst_n && m_valid && m_ready) begin
      outs++;
      last_out = m_data;
      checks++;
      assert (sb.size() > 0) begin
        passed++;
      end else begin
        $error("FAIL sb_empty observed=%h expected=none", m_data);
      end
      if (sb.size() > 0) chk("frame", {32'd0, m_data}, {32'd0, sb.pop_front()});
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("s_ready_timeout", 128'(n), 128'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int seed, input int nbeats,
                            input int last_at, input bit push);
    logic [95:0] exp;
    logic [63:0] d;
    int v;
    exp = '0;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      for (int j = 0; j < 4; j++) begin
        v = raw(mode, seed, b, j);
        d[j*16 +: 16] = 16'(v);
        if (b < 12) exp[(b*4+j)*2 +: 2] = q_ref(v);
      end
      if (push && b == nbeats - 1) sb.push_back(exp);
      send_beat(d, b == last_at);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  int bad_d;
  int bad_r;
  int e0;
  int o0;
  logic [95:0] hold_exp;

  initial begin
    checks = 0; passed = 0; errs = 0; outs = 0; last_out = '0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1;
    #12;
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_frame_err", 128'(frame_err), 128'd0);
    chk("rst_m_data", 128'(m_data), 128'd0);
    chk("rst_s_ready", 128'(s_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // quantizer lanes, latency, handoff bubble
    send_frame(2, 0, 12, 11, 1);
    chk("lat_m_valid", 128'(m_valid), 128'd1);
    chk("hold_s_ready", 128'(s_ready), 128'd0);
    @(posedge clk);
    #1;
    chk("post_m_valid", 128'(m_valid), 128'd0);
    chk("post_s_ready", 128'(s_ready), 128'd1);
    drain();
    chk("quant_lanes", 128'(last_out[7:0]), 128'h00f4);

    // uniform 0x0010 frame
    send_frame(0, 16, 12, 11, 1);
    drain();
    chk("all_01", 128'(last_out), {32'd0, {48{2'b01}}});

    // backpressure
    m_ready = 1'b0;
    send_frame(1, 3, 12, 11, 1);
    hold_exp = sb[0];
    bad_d = 0;
    bad_r = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_data !== hold_exp || m_valid !== 1'b1) bad_d++;
      if (s_ready !== 1'b0) bad_r++;
    end
    chk("bp_data_stable", 128'(bad_d), 128'd0);
    chk("bp_s_ready_low", 128'(bad_r), 128'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff_s_ready", 128'(s_ready), 128'd0);
    @(posedge clk);
    #1;
    chk("bp_bubble_s_ready", 128'(s_ready), 128'd1);
    chk("bp_bubble_m_valid", 128'(m_valid), 128'd0);
    send_frame(1, 4, 12, 11, 1);
    drain();

    // early last on beat 5
    e0 = errs;
    o0 = outs;
    send_frame(1, 5, 5, 4, 0);
    repeat (3) @(negedge clk);
    chk("early_err", 128'(errs - e0), 128'd1);
    chk("early_no_out", 128'(outs - o0), 128'd0);
    send_frame(1, 6, 12, 11, 1);
    drain();

    // missing last then resync
    e0 = errs;
    o0 = outs;
    send_frame(1, 7, 12, -1, 0);
    send_frame(1, 8, 3, 2, 0);
    repeat (3) @(negedge clk);
    chk("miss_err", 128'(errs - e0), 128'd1);
    chk("miss_no_out", 128'(outs - o0), 128'd0);
    send_frame(1, 9, 12, 11, 1);
    drain();
    chk("miss_clean_out", 128'(outs - o0), 128'd1);

    // async reset mid-frame
    e0 = errs;
    o0 = outs;
    send_frame(1, 10, 7, -1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 128'(m_valid), 128'd0);
    chk("arst_frame_err", 128'(frame_err), 128'd0);
    chk("arst_s_ready", 128'(s_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1, 11, 12, 11, 1);
    drain();
    chk("arst_no_err", 128'(errs - e0), 128'd0);
    chk("arst_one_out", 128'(outs - o0), 128'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
